// File: rtl/pipe_chain.sv
// pipe_chain: elastic valid/ready register chain with bubble collapse, per-stage flush and occupancy.
// Define PIPE_DROP_CNT_EN to build the saturating flushed-entry counter on drop_cnt (tied to 0 otherwise).
module pipe_chain #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_rdy,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_rdy,
  input  logic [DEPTH-1:0]  flush_mask,
  output logic [CNT_W-1:0]  occupancy,
  output logic [15:0]       drop_cnt
);

  logic [DEPTH-1:0]  r_vld;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [CNT_W-1:0]  r_occ;

  logic [DEPTH:0]    w_en;
  logic [DEPTH-1:0]  w_vldSrc;
  logic [DATA_W-1:0] w_dataSrc [DEPTH];
  logic [DEPTH-1:0]  w_vldLoad;
  logic [DEPTH-1:0]  w_vldNext;

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // A stage advances when it is empty or the stage ahead of it advances.
  always_comb begin
    w_en = '0;
    w_en[DEPTH] = out_rdy;
    for (int i = DEPTH - 1; i >= 0; i--) w_en[i] = ~r_vld[i] | w_en[i+1];
  end

  assign w_dataSrc[0] = in_data;
  generate
    if (DEPTH == 1) begin : g_src1
      assign w_vldSrc = in_vld;
    end else begin : g_srcN
      assign w_vldSrc = {r_vld[DEPTH-2:0], in_vld};
      for (genvar g = 1; g < DEPTH; g++) begin : g_dsrc
        assign w_dataSrc[g] = r_data[g-1];
      end
    end
  endgenerate

  assign w_vldLoad = (w_en[DEPTH-1:0] & w_vldSrc) | (~w_en[DEPTH-1:0] & r_vld);
  assign w_vldNext = w_vldLoad & ~flush_mask;

  // Flush only clears valid bits; payload still moves so the enables stay independent of flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_occ <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      r_vld <= w_vldNext;
      r_occ <= popcount(w_vldNext);
      for (int i = 0; i < DEPTH; i++) begin
        if (w_en[i]) r_data[i] <= w_dataSrc[i];
      end
    end
  end

  assign in_rdy    = w_en[0];
  assign out_vld   = r_vld[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign occupancy = r_occ;

`ifdef PIPE_DROP_CNT_EN
  logic [15:0]      r_dropCnt;
  logic [CNT_W-1:0] w_dropNow;
  logic [16:0]      w_dropSum;

  // Entries that would have been valid after this edge but are squashed, including a fresh input.
  assign w_dropNow = popcount(w_vldLoad & flush_mask);
  assign w_dropSum = {1'b0, r_dropCnt} + 17'(w_dropNow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dropCnt <= '0;
    else        r_dropCnt <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
  end

  assign drop_cnt = r_dropCnt;
`else
  assign drop_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed scenarios plus randomized traffic against a slot-level reference model.
module tb_pipe_chain;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              in_vld;
  logic [DATA_W-1:0] in_data;
  logic              in_rdy;
  logic              out_vld;
  logic [DATA_W-1:0] out_data;
  logic              out_rdy;
  logic [DEPTH-1:0]  flush_mask;
  logic [CNT_W-1:0]  occupancy;
  logic [15:0]       drop_cnt;

  int nChecks = 0;
  int nFails  = 0;

  bit                mVld  [DEPTH];
  logic [DATA_W-1:0] mData [DEPTH];
  int                mDrop;

  pipe_chain #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy),
    .flush_mask(flush_mask), .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  function automatic int modelOcc();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(mVld[i]);
    return c;
  endfunction

  // Input is accepted unless every slot is full and nothing leaves.
  function automatic bit modelInRdy();
    return out_rdy || (modelOcc() < DEPTH);
  endfunction

  function automatic logic [15:0] expDrop();
`ifdef PIPE_DROP_CNT_EN
    return 16'(mDrop);
`else
    return 16'h0;
`endif
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      mVld[i]  = 1'b0;
      mData[i] = '0;
    end
    mDrop = 0;
  endtask

  // Held entries form a solid block at the output end; everything below that block moves up one slot.
  task automatic modelEdge();
    bit                nV [DEPTH];
    logic [DATA_W-1:0] nD [DEPTH];
    int h;
    for (int i = 0; i < DEPTH; i++) begin
      nV[i] = mVld[i];
      nD[i] = mData[i];
    end
    h = DEPTH;
    if (!out_rdy) while (h > 0 && mVld[h-1]) h--;
    for (int i = h - 1; i >= 1; i--) begin
      nV[i] = mVld[i-1];
      nD[i] = mData[i-1];
    end
    if (h > 0) begin
      nV[0] = in_vld;
      nD[0] = in_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (nV[i] && flush_mask[i]) begin
        nV[i] = 1'b0;
        if (mDrop < 65535) mDrop++;
      end
      mVld[i]  = nV[i];
      mData[i] = nD[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) modelEdge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_vld = 1'b0; in_data = '0; out_rdy = 1'b0; flush_mask = '0;
    rst_n = 1'b0;
    modelReset();
    #2;
    nChecks++; if (out_vld !== 1'b0) begin nFails++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
    nChecks++; if (out_data !== '0) begin nFails++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    nChecks++; if (occupancy !== '0) begin nFails++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    nChecks++; if (in_rdy !== 1'b1) begin nFails++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
    nChecks++; if (drop_cnt !== 16'h0) begin nFails++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_vld = 1'b1; in_data = 32'h31 + k;
      tick();
    end
    in_vld = 1'b0;
    nChecks++; if (occupancy !== 3'd3) begin nFails++; $display("FAIL pre_reset_occ: got %0d want 3", occupancy); end
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    nChecks++; if (out_vld !== 1'b0) begin nFails++; $display("FAIL midreset_out_vld: got %b want 0", out_vld); end
    nChecks++; if (out_data !== '0) begin nFails++; $display("FAIL midreset_out_data: got %h want 0", out_data); end
    nChecks++; if (occupancy !== '0) begin nFails++; $display("FAIL midreset_occ: got %0d want 0", occupancy); end
    nChecks++; if (in_rdy !== 1'b1) begin nFails++; $display("FAIL midreset_in_rdy: got %b want 1", in_rdy); end
    in_vld = 1'b1; in_data = 32'h77;
    tick();
    nChecks++; if (occupancy !== '0) begin nFails++; $display("FAIL inreset_no_accept: occ got %0d want 0", occupancy); end
    rst_n = 1'b1;
    in_data = 32'h40; out_rdy = 1'b1;
    #1;
    nChecks++; if (in_rdy !== 1'b1) begin nFails++; $display("FAIL post_reset_in_rdy: got %b want 1", in_rdy); end
    tick();
    in_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nChecks++; if (out_vld !== 1'b0) begin nFails++; $display("FAIL post_reset_early_vld[%0d]: got %b want 0", k, out_vld); end
      tick();
    end
    nChecks++; if (out_vld !== 1'b1 || out_data !== 32'h40) begin nFails++; $display("FAIL post_reset_out: vld %b data %h want 1 00000040", out_vld, out_data); end
    tick();
    nChecks++; if (occupancy !== '0) begin nFails++; $display("FAIL post_reset_drain: occ got %0d want 0", occupancy); end
  endtask

  task automatic test_streaming();
    bit expV;
    out_rdy = 1'b1; flush_mask = '0;
    for (int k = 0; k < 8; k++) begin
      in_vld = (k < 4); in_data = 32'h11 + k;
      #1;
      nChecks++; if (in_rdy !== 1'b1) begin nFails++; $display("FAIL stream_in_rdy[%0d]: got %b want 1", k, in_rdy); end
      tick();
      expV = (k >= 3) && (k <= 6);
      nChecks++; if (out_vld !== expV) begin nFails++; $display("FAIL stream_vld[%0d]: got %b want %b", k, out_vld, expV); end
      if (expV) begin
        nChecks++; if (out_data !== 32'h11 + k - 3) begin nFails++; $display("FAIL stream_data[%0d]: got %h want %h", k, out_data, 32'h11 + k - 3); end
      end
    end
    in_vld = 1'b0;
  endtask

  task automatic test_backpressure();
    int idx = 0;
    bit acc;
    logic [DATA_W-1:0] got [$];
    out_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_vld = 1'b1; in_data = 32'hA0 + idx;
      #1;
      nChecks++; if (in_rdy !== (c < 4)) begin nFails++; $display("FAIL bp_in_rdy[%0d]: got %b want %b", c, in_rdy, c < 4); end
      acc = in_rdy;
      tick();
      if (acc) idx++;
    end
    nChecks++; if (occupancy !== 3'd4) begin nFails++; $display("FAIL bp_full_occ: got %0d want 4", occupancy); end
    out_rdy = 1'b1;
    for (int c = 0; c < 20 && got.size() < 6; c++) begin
      in_vld = (idx < 6); in_data = 32'hA0 + idx;
      #1;
      acc = in_vld && in_rdy;
      if (out_vld) got.push_back(out_data);
      tick();
      if (acc) idx++;
    end
    in_vld = 1'b0;
    nChecks++; if (got.size() != 6) begin nFails++; $display("FAIL bp_out_count: got %0d want 6", got.size()); end
    for (int j = 0; j < got.size() && j < 6; j++) begin
      nChecks++; if (got[j] !== 32'hA0 + j) begin nFails++; $display("FAIL bp_order[%0d]: got %h want %h", j, got[j], 32'hA0 + j); end
    end
    nChecks++; if (occupancy !== '0) begin nFails++; $display("FAIL bp_drain_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_bubble();
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = 32'hB0; tick();
    in_vld = 1'b0; tick(); tick();
    in_vld = 1'b1; in_data = 32'hB1; tick();
    in_vld = 1'b0; tick(); tick(); tick();
    #1;
    nChecks++; if (occupancy !== 3'd2) begin nFails++; $display("FAIL bubble_occ: got %0d want 2", occupancy); end
    nChecks++; if (in_rdy !== 1'b1) begin nFails++; $display("FAIL bubble_in_rdy: got %b want 1", in_rdy); end
    nChecks++; if (out_vld !== 1'b1 || out_data !== 32'hB0) begin nFails++; $display("FAIL bubble_head: vld %b data %h want 1 000000b0", out_vld, out_data); end
    out_rdy = 1'b1;
    tick();
    nChecks++; if (out_vld !== 1'b1 || out_data !== 32'hB1) begin nFails++; $display("FAIL bubble_packed: vld %b data %h want 1 000000b1", out_vld, out_data); end
    tick();
    nChecks++; if (occupancy !== '0) begin nFails++; $display("FAIL bubble_drain: occ got %0d want 0", occupancy); end
    out_rdy = 1'b0;
  endtask

  task automatic test_flush();
    logic [DATA_W-1:0] got [$];
    logic [15:0] wantDrop;
    out_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_vld = 1'b1; in_data = 32'hC0 + k; tick();
    end
    in_vld = 1'b0;
    nChecks++; if (occupancy !== 3'd4 || out_data !== 32'hC0) begin nFails++; $display("FAIL flush_fill: occ %0d data %h want 4 000000c0", occupancy, out_data); end
    flush_mask = 4'b0011;
    tick();
    flush_mask = '0;
`ifdef PIPE_DROP_CNT_EN
    wantDrop = 16'd2;
`else
    wantDrop = 16'd0;
`endif
    nChecks++; if (occupancy !== 3'd2) begin nFails++; $display("FAIL flush_occ: got %0d want 2", occupancy); end
    nChecks++; if (drop_cnt !== wantDrop) begin nFails++; $display("FAIL flush_drop: got %0d want %0d", drop_cnt, wantDrop); end
    out_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (out_vld) got.push_back(out_data);
      tick();
    end
    nChecks++; if (got.size() != 2) begin nFails++; $display("FAIL flush_out_count: got %0d want 2", got.size()); end
    if (got.size() >= 2) begin
      nChecks++; if (got[0] !== 32'hC0 || got[1] !== 32'hC1) begin nFails++; $display("FAIL flush_survivors: got %h %h want c0 c1", got[0], got[1]); end
    end
  endtask

  task automatic test_flush_accept();
    int seen = 0;
    logic [15:0] wantDrop;
    out_rdy = 1'b1;
    in_vld = 1'b1; in_data = 32'hD0; flush_mask = 4'b0001;
    #1;
    nChecks++; if (in_rdy !== 1'b1) begin nFails++; $display("FAIL fa_in_rdy: got %b want 1", in_rdy); end
    tick();
    in_vld = 1'b0; flush_mask = '0;
    nChecks++; if (occupancy !== '0) begin nFails++; $display("FAIL fa_occ: got %0d want 0", occupancy); end
    for (int c = 0; c < 6; c++) begin
      if (out_vld && out_data === 32'hD0) seen++;
      tick();
    end
    nChecks++; if (seen != 0) begin nFails++; $display("FAIL fa_leak: squashed word seen %0d times want 0", seen); end
`ifdef PIPE_DROP_CNT_EN
    wantDrop = 16'd3;
`else
    wantDrop = 16'd0;
`endif
    nChecks++; if (drop_cnt !== wantDrop) begin nFails++; $display("FAIL fa_drop: got %0d want %0d", drop_cnt, wantDrop); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_vld = 1'($urandom_range(0, 1));
      in_data = $urandom;
      out_rdy = ($urandom_range(0, 3) != 0);
      flush_mask = ($urandom_range(0, 7) == 0) ? DEPTH'($urandom) : '0;
      #1;
      nChecks++; if (in_rdy !== modelInRdy()) begin nFails++; $display("FAIL rnd_in_rdy[%0d]: got %b want %b", c, in_rdy, modelInRdy()); end
      tick();
      nChecks++; if (out_vld !== mVld[DEPTH-1]) begin nFails++; $display("FAIL rnd_out_vld[%0d]: got %b want %b", c, out_vld, mVld[DEPTH-1]); end
      if (mVld[DEPTH-1]) begin
        nChecks++; if (out_data !== mData[DEPTH-1]) begin nFails++; $display("FAIL rnd_out_data[%0d]: got %h want %h", c, out_data, mData[DEPTH-1]); end
      end
      nChecks++; if (occupancy !== CNT_W'(modelOcc())) begin nFails++; $display("FAIL rnd_occ[%0d]: got %0d want %0d", c, occupancy, modelOcc()); end
      nChecks++; if (drop_cnt !== expDrop()) begin nFails++; $display("FAIL rnd_drop[%0d]: got %0d want %0d", c, drop_cnt, expDrop()); end
    end
    in_vld = 1'b0; flush_mask = '0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_flush_accept();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
